// File: rtl/rambam_sbox_ctrl.sv
// Handshake controller for the redundant-encoded S-box: holds plaintext and refresh
// randomness for LAT cycles, then samples the S-box result. RAMBAM_RAND_EN enables randomness.
module rambam_sbox_ctrl #(
  parameter int          d         = 2,
  parameter int          LAT       = 7,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8+d-1:0]       in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8+d-1:0]       out_data,
  output logic [8+d-1:0]       sbox_pt,
  output logic [6:0][d-1:0]    sbox_r,
  input  logic [8+d-1:0]       sbox_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       accept;

  if (LAT < 6 || LAT > 15) begin : g_lat_chk
    $error("rambam_sbox_ctrl: LAT must be within 6..15");
  end
  if (LFSR_SEED == 32'd0) begin : g_seed_chk
    $error("rambam_sbox_ctrl: LFSR_SEED must be nonzero");
  end

  // in_ready is registered and high only in IDLE, so this is the IDLE acceptance.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      sbox_pt   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= RUN;
            sbox_pt   <= in_data;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= DONE;
            out_data  <= sbox_out;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE first; the next acceptance waits one cycle.
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAMBAM_RAND_EN
  logic [31:0]    lfsr_reg;
  logic [31:0]    lfsr_next;
  logic [7*d-1:0] pool_reg;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 32'h8020_0003) : (lfsr_reg >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
      pool_reg <= '0;
      sbox_r   <= '0;
    end else begin
      lfsr_reg <= lfsr_next;
      pool_reg <= {pool_reg[7*d-2:0], lfsr_reg[0]};
      if (accept) begin
        sbox_r <= pool_reg;
      end
    end
  end
`else
  assign sbox_r = '0;
`endif

endmodule

// File: tb/tb_rambam_sbox_ctrl.sv
// Bench for rambam_sbox_ctrl with a behavioural S-box (GF(2^8) inverse + affine) on the
// redundant encoding x + k*P, P = 0x11B; results are decoded by reduction mod P.
module tb_rambam_sbox_ctrl;
  localparam int D   = 2;
  localparam int LAT = 7;
  localparam int W   = 8 + D;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [W-1:0]       in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic               busy;
  logic [W-1:0]       out_data;
  logic [W-1:0]       sbox_pt;
  logic [6:0][D-1:0]  sbox_r;
  logic [W-1:0]       sbox_out;

  always #5 clk = ~clk;

  rambam_sbox_ctrl #(.d(D), .LAT(LAT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sbox_pt(sbox_pt), .sbox_r(sbox_r), .sbox_out(sbox_out), .busy(busy)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [W-1:0] encode(logic [7:0] x, logic [D-1:0] k);
    logic [W-1:0] e = W'(x);
    for (int j = 0; j < D; j++) if (k[j]) e = e ^ (W'(9'h11B) << j);
    return e;
  endfunction

  function automatic logic [7:0] decode(logic [W-1:0] e);
    for (int i = W - 1; i >= 8; i--) if (e[i]) e = e ^ (W'(9'h11B) << (i - 8));
    return e[7:0];
  endfunction

  // S-box model: junk until its input has been stable for a few cycles.
  logic [W-1:0] last_pt = '1;
  logic [W-1:0] good_out = '0;
  logic [W-1:0] junk = '0;
  int           age = 0;
  always @(posedge clk) begin
    junk <= W'($urandom);
    if (sbox_pt !== last_pt) begin
      last_pt  <= sbox_pt;
      age      <= 0;
      good_out <= encode(aes_sbox(decode(sbox_pt)), D'($urandom));
    end else if (age < 15) begin
      age <= age + 1;
    end
  end
  assign sbox_out = (age >= 4) ? good_out : junk;

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                n_acc = 0;
  logic [7:0]        exp_q[$];
  int                acc_q[$];
  logic [W-1:0]      pt_held = '0;
  logic [W-1:0]      od_held = '0;
  bit                pt_valid = 1'b0;
  bit                prev_ov = 1'b0;
  bit                prev_hs = 1'b0;
  bit                prev_acc = 1'b0;
  logic [6:0][D-1:0] r_first = '0;
  bit                r_seen = 1'b0;
  bit                r_diff = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Called at a falling edge: checks the current cycle, updates the model, advances one cycle.
  task automatic tick();
    bit hs_now;
    bit acc_now;
    cyc++;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      pt_held  = '0;
      pt_valid = 1'b1;
      od_held  = '0;
      prev_ov  = 1'b0;
      prev_hs  = 1'b0;
      prev_acc = 1'b0;
    end else begin
      chk("in_ready_vs_idle", in_ready, !busy);
      if (prev_hs) begin
        chk("bubble_busy", busy, 0);
        chk("bubble_out_valid", out_valid, 0);
        chk("out_data_hold", out_data, od_held);
      end
      if (prev_acc) begin
`ifdef RAMBAM_RAND_EN
        if (!r_seen) begin r_first = sbox_r; r_seen = 1'b1; end
        else if (sbox_r !== r_first) r_diff = 1'b1;
`else
        chk("sbox_r_zero", sbox_r, 0);
`endif
      end
      if (pt_valid) chk("sbox_pt_hold", sbox_pt, pt_held);
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
          end else begin
            chk("latency", cyc - acc_q[0], LAT + 1);
            chk("result", decode(out_data), exp_q[0]);
          end
          od_held = out_data;
        end else begin
          chk("out_data_stable", out_data, od_held);
        end
        if (out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      hs_now  = out_valid && out_ready;
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        exp_q.push_back(aes_sbox(decode(in_data)));
        acc_q.push_back(cyc);
        pt_held  = in_data;
        pt_valid = 1'b1;
        n_acc++;
      end
      prev_ov  = out_valid;
      prev_hs  = hs_now;
      prev_acc = acc_now;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || busy); i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    int ovs;
    int budget;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sbox_pt", sbox_pt, 0);
    chk("rst_sbox_r", sbox_r, 0);
    tick();

    // Encoded 0x00 offered in the first cycle after reset release.
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = encode(8'h00, D'($urandom));
    out_ready = 1'b1;
    tick();
    chk("first_accept", n_acc, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    chk("zero_out_valid", out_valid, 1);
    chk("zero_result", decode(out_data), 8'h63);
    tick();
    chk("zero_busy_falls", busy, 0);
    repeat (3) tick();

    // All 256 byte values back to back, fresh encoding each cycle.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    budget    = 0;
    for (int v = 0; v < 256 && budget < 5000; budget++) begin
      in_data = encode(8'(v), D'($urandom));
      tick();
      if (prev_acc) v++;
    end
    chk("all_bytes_accepted", n_acc, 257);
    drain();
`ifdef RAMBAM_RAND_EN
    chk("sbox_r_varies", r_diff, 1);
`endif

    // Stall in DONE with in_valid held high.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = encode(8'($urandom), D'($urandom));
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    chk("stall_out_valid", out_valid, 1);
    repeat (5) tick();
    n0 = n_acc;
    out_ready = 1'b1;
    tick();
    chk("stall_no_accept_at_hs", n_acc - n0, 0);
    tick();
    tick();
    chk("stall_one_accept", n_acc - n0, 1);
    chk("stall_busy_again", busy, 1);
    drain();

    // Reset in RUN with counter at 3.
    in_valid = 1'b1;
    in_data  = encode(8'($urandom), D'($urandom));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_in_ready", in_ready, 1);
    chk("rstrun_out_valid", out_valid, 0);
    chk("rstrun_sbox_pt", sbox_pt, 0);
    chk("rstrun_sbox_r", sbox_r, 0);
`ifdef RAMBAM_RAND_EN
    chk("rstrun_lfsr", dut.lfsr_reg, SEED);
`endif
    @(negedge clk);
    tick();
    rst = 1'b0;
    ovs = 0;
    repeat (20) begin
      tick();
      ovs += int'(out_valid);
    end
    chk("rstrun_no_result", ovs, 0);

    // in_data and in_valid churn during RUN.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = encode(8'($urandom), D'($urandom));
    tick();
    repeat (12) begin
      in_data  = W'($urandom);
      in_valid = 1'($urandom);
      tick();
    end
    drain();

    // Random traffic with back-pressure.
    repeat (400) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = encode(8'($urandom), D'($urandom));
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
